// File: rtl/dht22_responder.sv
// ============================================================================
// Module   : dht22_responder
// Purpose  : DHT22 single-wire sensor emulator. It answers a host start pulse
//            with the ack pair, the 40-bit frame and the end-of-transmission low.
// Options  : `define DHT22_CRC_INJ_EN adds crc_corrupt to flip checksum bit 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dht22_responder #(
  parameter int CLKS_PER_US  = 50,
  parameter int START_MIN_US = 400,
  parameter int TURN_US      = 30,
  parameter int ACK_US       = 80,
  parameter int BIT_LOW_US   = 50,
  parameter int BIT0_US      = 26,
  parameter int BIT1_US      = 70
) (
  input  logic        clk,
  input  logic        res,
  inout  wire         dht22,
  input  logic [15:0] hum,
  input  logic [15:0] temp,
  input  logic        load,
`ifdef DHT22_CRC_INJ_EN
  input  logic        crc_corrupt,
`endif
  output logic        busy,
  output logic        frame_done,
  output logic        start_err
);

  localparam int PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

  localparam logic [PRE_W-1:0] c_pre_last     = PRE_W'(CLKS_PER_US - 1);
  localparam logic [15:0]      c_start_min_us = 16'(START_MIN_US);
  localparam logic [15:0]      c_turn_us      = 16'(TURN_US);
  localparam logic [15:0]      c_ack_us       = 16'(ACK_US);
  localparam logic [15:0]      c_bit_low_us   = 16'(BIT_LOW_US);
  localparam logic [15:0]      c_bit0_us      = 16'(BIT0_US);
  localparam logic [15:0]      c_bit1_us      = 16'(BIT1_US);
  localparam logic [15:0]      c_us_max       = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HOST_LOW = 3'd1,
    S_TURN     = 3'd2,
    S_ACK_LOW  = 3'd3,
    S_ACK_HIGH = 3'd4,
    S_BIT_LOW  = 3'd5,
    S_BIT_HIGH = 3'd6,
    S_EOT_LOW  = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [15:0]        us_q, us_d;
  logic [31:0]        shadow_q, shadow_d;
  logic [39:0]        frame_q, frame_d;
  logic [5:0]         idx_q, idx_d;
  logic               sync1_q, sync2_q, prev_q;

  logic               w_tick;
  logic               w_fall;
  logic               w_rise;
  logic               w_done;
  logic               w_drive_low;
  logic [15:0]        w_target;
  logic [7:0]         w_chk_raw;
  logic [7:0]         w_chk;

  // Open-drain: the pad is only ever pulled low or released.
  assign dht22 = w_drive_low ? 1'b0 : 1'bz;

  assign w_tick = (pre_q == c_pre_last);
  assign w_fall = prev_q & ~sync2_q;
  assign w_rise = ~prev_q & sync2_q;

  assign w_chk_raw = shadow_q[31:24] + shadow_q[23:16] + shadow_q[15:8] + shadow_q[7:0];
`ifdef DHT22_CRC_INJ_EN
  assign w_chk = w_chk_raw ^ {7'd0, crc_corrupt};
`else
  assign w_chk = w_chk_raw;
`endif

  always_comb begin
    w_target = c_us_max;
    case (state_q)
      S_TURN:                w_target = c_turn_us;
      S_ACK_LOW, S_ACK_HIGH: w_target = c_ack_us;
      S_BIT_LOW, S_EOT_LOW:  w_target = c_bit_low_us;
      S_BIT_HIGH:            w_target = frame_q[idx_q] ? c_bit1_us : c_bit0_us;
      default:               w_target = c_us_max;
    endcase
  end

  // The Nth tick since state entry ends an N us phase.
  assign w_done = w_tick && (us_q == (w_target - 16'd1));

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    idx_d       = idx_q;
    busy        = 1'b0;
    w_drive_low = 1'b0;
    frame_done  = 1'b0;
    start_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_fall) state_d = S_HOST_LOW;
      end
      S_HOST_LOW: begin
        if (w_rise) begin
          if (us_q >= c_start_min_us) begin
            state_d = S_TURN;
            frame_d = {shadow_q, w_chk};
            idx_d   = 6'd39;
          end else begin
            state_d   = S_IDLE;
            start_err = 1'b1;
          end
        end
      end
      S_TURN: begin
        busy = 1'b1;
        if (w_done) state_d = S_ACK_LOW;
      end
      S_ACK_LOW: begin
        busy        = 1'b1;
        w_drive_low = 1'b1;
        if (w_done) state_d = S_ACK_HIGH;
      end
      S_ACK_HIGH: begin
        busy = 1'b1;
        if (w_done) state_d = S_BIT_LOW;
      end
      S_BIT_LOW: begin
        busy        = 1'b1;
        w_drive_low = 1'b1;
        if (w_done) state_d = S_BIT_HIGH;
      end
      S_BIT_HIGH: begin
        busy = 1'b1;
        if (w_done) begin
          if (idx_q == 6'd0) begin
            state_d = S_EOT_LOW;
          end else begin
            idx_d   = idx_q - 6'd1;
            state_d = S_BIT_LOW;
          end
        end
      end
      S_EOT_LOW: begin
        busy        = 1'b1;
        w_drive_low = 1'b1;
        if (w_done) begin
          state_d    = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Prescaler and us counter restart on every state change so phases are exact.
  always_comb begin
    pre_d    = pre_q;
    us_d     = us_q;
    shadow_d = load ? {hum, temp} : shadow_q;
    if (state_d != state_q) begin
      pre_d = '0;
      us_d  = '0;
    end else if (w_tick) begin
      pre_d = '0;
      if (us_q != c_us_max) us_d = us_q + 16'd1;
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= S_IDLE;
      pre_q    <= '0;
      us_q     <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      idx_q    <= '0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      us_q     <= us_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      idx_q    <= idx_d;
      sync1_q  <= dht22;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dht22_responder.sv
// ============================================================================
// Module   : tb_dht22_responder
// Purpose  : Self-checking bench for dht22_responder acting as the DHT22 host.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dht22_responder;

  localparam int CLKS       = 2;
  localparam int TURN_US    = 30;
  localparam int ACK_US     = 80;
  localparam int BIT_LOW_US = 50;
  localparam int BIT0_US    = 26;
  localparam int BIT1_US    = 70;
  localparam int BOUND      = 2000;

  logic        clk      = 1'b0;
  logic        res      = 1'b0;
  logic        host_low = 1'b0;
  logic        load     = 1'b0;
  logic [15:0] hum      = 16'h0000;
  logic [15:0] temp     = 16'h0000;
  logic        busy;
  logic        frame_done;
  logic        start_err;
`ifdef DHT22_CRC_INJ_EN
  logic        crc_corrupt = 1'b0;
`endif

  wire dht22;
  assign dht22 = host_low ? 1'b0 : 1'bz;
  pullup (dht22);

  dht22_responder #(.CLKS_PER_US(CLKS)) dut (
    .clk        (clk),
    .res        (res),
    .dht22      (dht22),
    .hum        (hum),
    .temp       (temp),
    .load       (load),
`ifdef DHT22_CRC_INJ_EN
    .crc_corrupt(crc_corrupt),
`endif
    .busy       (busy),
    .frame_done (frame_done),
    .start_err  (start_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fd_cnt   = 0;
  int se_cnt   = 0;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (start_err === 1'b1) se_cnt++;
  end

  typedef struct {
    logic [15:0] hum;
    logic [15:0] temp;
    logic [39:0] frame;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Counts consecutive negedge samples at level lvl, starting with the current one.
  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (dht22 === lvl) begin
      n++;
      if (n > BOUND) begin
        n = -1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic host_pulse(input int us);
    @(negedge clk);
    host_low = 1'b1;
    repeat (us * CLKS) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic load_vals(input logic [15:0] h, input logic [15:0] t);
    @(negedge clk);
    hum  = h;
    temp = t;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [39:0] exp, input int load_bit,
                           input logic [15:0] nh, input logic [15:0] nt);
    int n;
    int extra;
    int fd0;
    int se0;
    int lowbad;
    int highbad;
    logic [39:0] got;
    fd0     = fd_cnt;
    se0     = se_cnt;
    lowbad  = 0;
    highbad = 0;
    got     = '0;
    host_pulse(500);
    @(negedge clk);
    measure(1'b1, n);
    check_rng({tag, " turn_gap"}, n, TURN_US * CLKS + 1, TURN_US * CLKS + 3);
    check({tag, " busy_in_frame"}, 64'(busy), 64'd1);
    measure(1'b0, n);
    check_rng({tag, " ack_low"}, n, ACK_US * CLKS - 1, ACK_US * CLKS + 1);
    measure(1'b1, n);
    check_rng({tag, " ack_high"}, n, ACK_US * CLKS - 1, ACK_US * CLKS + 1);
    for (int i = 39; i >= 0; i--) begin
      measure(1'b0, n);
      if (n < 0) begin
        lowbad++;
        break;
      end
      if (n < BIT_LOW_US * CLKS - 1 || n > BIT_LOW_US * CLKS + 1) lowbad++;
      extra = 0;
      if (i == load_bit) begin
        hum   = nh;
        temp  = nt;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        extra = 1;
      end
      measure(1'b1, n);
      if (n < 0) begin
        highbad++;
        break;
      end
      n += extra;
      got[i] = (n > ((BIT0_US + BIT1_US) * CLKS) / 2);
      if (!((n >= BIT0_US * CLKS - 1 && n <= BIT0_US * CLKS + 1) ||
            (n >= BIT1_US * CLKS - 1 && n <= BIT1_US * CLKS + 1))) highbad++;
    end
    check({tag, " bit_low_widths_bad"}, 64'(lowbad), 64'd0);
    check({tag, " bit_high_widths_bad"}, 64'(highbad), 64'd0);
    check({tag, " frame"}, 64'(got), 64'(exp));
    measure(1'b0, n);
    check_rng({tag, " eot_low"}, n, BIT_LOW_US * CLKS - 1, BIT_LOW_US * CLKS + 1);
    repeat (4) @(negedge clk);
    check({tag, " busy_after"}, 64'(busy), 64'd0);
    check({tag, " frame_done_pulses"}, 64'(fd_cnt - fd0), 64'd1);
    check({tag, " start_err_pulses"}, 64'(se_cnt - se0), 64'd0);
  endtask

  initial begin
    int n;
    int drv;
    int bsy;
    int se0;

    vecs[0] = '{16'h028C, 16'h015F, 40'h028C015FEE};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 40'hFFFFFFFFFC};
    vecs[2] = '{16'h1234, 16'h5678, 40'h1234567814};

    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset frame_done", 64'(frame_done), 64'd0);
    check("reset start_err", 64'(start_err), 64'd0);
    check("reset bus released", 64'(dht22), 64'd1);
    res = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      load_vals(vecs[v].hum, vecs[v].temp);
      run_frame($sformatf("vec%0d", v), vecs[v].frame, -1, 16'h0, 16'h0);
    end

    // Too-short host low: error pulse, no response.
    se0 = se_cnt;
    drv = 0;
    bsy = 0;
    host_pulse(200);
    repeat ((TURN_US + 2 * ACK_US) * CLKS) begin
      @(negedge clk);
      if (dht22 !== 1'b1) drv++;
      if (busy !== 1'b0) bsy++;
    end
    check("short start_err_pulses", 64'(se_cnt - se0), 64'd1);
    check("short bus_driven_samples", 64'(drv), 64'd0);
    check("short busy_samples", 64'(bsy), 64'd0);

    // Load during bit 20: current frame keeps old data, next frame has new data.
    run_frame("midload_cur", 40'h1234567814, 20, 16'hA55A, 16'h0F0F);
    run_frame("midload_next", 40'hA55A0F0F1D, -1, 16'h0, 16'h0);

    // Async reset during ACK_LOW releases the bus before the next clock edge.
    host_pulse(500);
    @(negedge clk);
    measure(1'b1, n);
    check("rst ack_low_seen", 64'(dht22), 64'd0);
    repeat (10) @(negedge clk);
    res = 1'b0;
    #1;
    check("rst bus released", 64'(dht22), 64'd1);
    check("rst busy", 64'(busy), 64'd0);
    @(negedge clk);
    res = 1'b1;
    repeat (3) @(negedge clk);
    load_vals(16'h028C, 16'h015F);
    run_frame("after_rst", 40'h028C015FEE, -1, 16'h0, 16'h0);

`ifdef DHT22_CRC_INJ_EN
    crc_corrupt = 1'b1;
    run_frame("crc_inj", 40'h028C015FEF, -1, 16'h0, 16'h0);
    crc_corrupt = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
